// File: rtl/fc_layer_sequencer.sv
// rtl/fc_layer_sequencer.sv - FC layer control FSM: input load, shared-MAC sequencing, output handshake (optional bias step: FC_SEQ_BIAS_EN)

module fc_layer_sequencer #(
   parameter int PREVIOUS_LAYER_HEIGHT = 4,
   parameter int LAYER_HEIGHT          = 2,
   parameter int IDX_W  = (PREVIOUS_LAYER_HEIGHT > 1) ? $clog2(PREVIOUS_LAYER_HEIGHT) : 1,
   parameter int NEU_W  = (LAYER_HEIGHT > 1) ? $clog2(LAYER_HEIGHT) : 1,
   parameter int ADDR_W = (LAYER_HEIGHT * PREVIOUS_LAYER_HEIGHT > 1) ?
                          $clog2(LAYER_HEIGHT * PREVIOUS_LAYER_HEIGHT) : 1
) (
   input  logic              clk_i,
   input  logic              reset_i,
   input  logic              empty_i,
   output logic              ren_o,
   output logic              in_wen_o,
   output logic [IDX_W-1:0]  in_addr_o,
   output logic [ADDR_W-1:0] weight_addr_o,
   output logic [IDX_W-1:0]  mac_sel_o,
   output logic              acc_clr_o,
   output logic              acc_en_o,
   output logic              bias_en_o,
   output logic              out_wen_o,
   output logic [NEU_W-1:0]  neuron_o,
   output logic              valid_o,
   input  logic              ready_i,
   output logic              busy_o
);

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PREVIOUS_LAYER_HEIGHT - 1);
   localparam logic [NEU_W-1:0] NEU_LAST = NEU_W'(LAYER_HEIGHT - 1);

   typedef enum logic [2:0] {
      S_LOAD    = 3'd0,
      S_COMPUTE = 3'd1,
      S_DRAIN   = 3'd2,
`ifdef FC_SEQ_BIAS_EN
      S_BIAS    = 3'd3,
`endif
      S_WRITE   = 3'd4,
      S_OUTPUT  = 3'd5
   } state_t;

   state_t              state;
   logic [IDX_W-1:0]    load_cnt;
   logic [IDX_W-1:0]    idx;
   logic [ADDR_W-1:0]   waddr;
   logic [NEU_W-1:0]    neuron;
   logic                acc_en_q;
   logic                acc_clr_q;
   logic                out_wen_q;
   logic                valid_q;
   logic                pop;

   // Pop whenever LOAD sees data; reset_i gates it so the pop is dead while reset is held
   assign pop       = (state == S_LOAD) && !empty_i && reset_i;
   assign ren_o     = pop;
   assign in_wen_o  = pop;
   assign in_addr_o = load_cnt;

   assign weight_addr_o = waddr;
   assign mac_sel_o     = idx;
   assign acc_en_o      = acc_en_q;
   assign acc_clr_o     = acc_clr_q;
   assign out_wen_o     = out_wen_q;
   assign neuron_o      = neuron;
   assign valid_o       = valid_q;
   assign busy_o        = !((state == S_LOAD) && (load_cnt == '0));

`ifdef FC_SEQ_BIAS_EN
   logic bias_q;
   assign bias_en_o = bias_q;
`else
   assign bias_en_o = 1'b0;
`endif

   // Main sequencer: load -> per-neuron compute/drain/(bias)/write -> output handshake
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state     <= S_LOAD;
         load_cnt  <= '0;
         idx       <= '0;
         waddr     <= '0;
         neuron    <= '0;
         acc_en_q  <= 1'b0;
         acc_clr_q <= 1'b0;
         out_wen_q <= 1'b0;
         valid_q   <= 1'b0;
`ifdef FC_SEQ_BIAS_EN
         bias_q    <= 1'b0;
`endif
      end else begin
         // Accumulator controls trail the address by one cycle to match the ROM read latency
         acc_en_q  <= (state == S_COMPUTE);
         acc_clr_q <= (state == S_COMPUTE) && (idx == '0);
         out_wen_q <= 1'b0;
`ifdef FC_SEQ_BIAS_EN
         bias_q    <= 1'b0;
`endif
         case (state)
            S_LOAD: begin
               if (!empty_i) begin
                  if (load_cnt == IDX_LAST) begin
                     state  <= S_COMPUTE;
                     idx    <= '0;
                     waddr  <= '0;
                     neuron <= '0;
                  end else begin
                     load_cnt <= load_cnt + 1'b1;
                  end
               end
            end
            S_COMPUTE: begin
               // The address stays on the last weight so it holds outside COMPUTE
               if (idx == IDX_LAST) begin
                  state <= S_DRAIN;
               end else begin
                  idx   <= idx + 1'b1;
                  waddr <= waddr + 1'b1;
               end
            end
            S_DRAIN: begin
`ifdef FC_SEQ_BIAS_EN
               state  <= S_BIAS;
               bias_q <= 1'b1;
`else
               state     <= S_WRITE;
               out_wen_q <= 1'b1;
`endif
            end
`ifdef FC_SEQ_BIAS_EN
            S_BIAS: begin
               state     <= S_WRITE;
               out_wen_q <= 1'b1;
            end
`endif
            S_WRITE: begin
               if (neuron == NEU_LAST) begin
                  state   <= S_OUTPUT;
                  valid_q <= 1'b1;
               end else begin
                  // Weights are stored neuron-major, so the next neuron starts one past the last address
                  state  <= S_COMPUTE;
                  neuron <= neuron + 1'b1;
                  idx    <= '0;
                  waddr  <= waddr + 1'b1;
               end
            end
            S_OUTPUT: begin
               if (ready_i) begin
                  state    <= S_LOAD;
                  valid_q  <= 1'b0;
                  load_cnt <= '0;
                  neuron   <= '0;
               end
            end
            default: begin
               state <= S_LOAD;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// tb/tb_fc_layer_sequencer.sv - self-checking bench for fc_layer_sequencer (P=4, H=2)

module tb_fc_layer_sequencer;

   localparam int P  = 4;
   localparam int H  = 2;
   localparam int IW = 2;
   localparam int NW = 1;
   localparam int AW = 3;
`ifdef FC_SEQ_BIAS_EN
   localparam int NC = P + 3;
   localparam int NB = 1;
`else
   localparam int NC = P + 2;
   localparam int NB = 0;
`endif
   localparam int LAT = H * NC;

   logic clk = 1'b0;
   logic reset_i = 1'b0;
   logic empty_i = 1'b1;
   logic ready_i = 1'b0;
   logic ren_o, in_wen_o, acc_clr_o, acc_en_o, bias_en_o, out_wen_o, valid_o, busy_o;
   logic [IW-1:0] in_addr_o, mac_sel_o;
   logic [AW-1:0] weight_addr_o;
   logic [NW-1:0] neuron_o;
   logic [15:0]   outs;

   assign outs = {ren_o, in_wen_o, in_addr_o, weight_addr_o, mac_sel_o, acc_clr_o,
                  acc_en_o, bias_en_o, out_wen_o, neuron_o, valid_o, busy_o};

   fc_layer_sequencer #(.PREVIOUS_LAYER_HEIGHT(P), .LAYER_HEIGHT(H)) dut (
      .clk_i(clk), .reset_i(reset_i), .empty_i(empty_i), .ren_o(ren_o),
      .in_wen_o(in_wen_o), .in_addr_o(in_addr_o), .weight_addr_o(weight_addr_o),
      .mac_sel_o(mac_sel_o), .acc_clr_o(acc_clr_o), .acc_en_o(acc_en_o),
      .bias_en_o(bias_en_o), .out_wen_o(out_wen_o), .neuron_o(neuron_o),
      .valid_o(valid_o), .ready_i(ready_i), .busy_o(busy_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;
   int pop_total = 0;
   int fifo_pushed = 0;
   int bias_cnt = 0;
   int pop_in_valid = 0;
   int wen_bad = 0;
   bit gap = 1'b0;

   logic [IW-1:0] obs_pop[$];
   int            obs_pop_cyc[$];
   logic [5:0]    obs_mac[$];
   logic [NW-1:0] obs_wr[$];
   int            obs_vrise[$];
   int            obs_vfall[$];
   logic [IW-1:0] exp_pop[$];
   logic [5:0]    exp_mac[$];
   logic [NW-1:0] exp_wr[$];

   logic          prev_valid = 1'b0;
   logic [AW-1:0] prev_waddr = '0;
   logic [IW-1:0] prev_sel = '0;

   // Observation monitor: records DUT events mid-cycle, away from the rising edge
   always @(negedge clk) begin
      if (reset_i) begin
         if (ren_o) begin
            obs_pop.push_back(in_addr_o);
            obs_pop_cyc.push_back(cyc);
            pop_total++;
            if (valid_o) pop_in_valid++;
            if (in_wen_o !== 1'b1) wen_bad++;
         end else if (in_wen_o !== 1'b0) begin
            wen_bad++;
         end
         if (acc_en_o) obs_mac.push_back({acc_clr_o, prev_waddr, prev_sel});
         if (out_wen_o) obs_wr.push_back(neuron_o);
         if (bias_en_o) bias_cnt++;
         if (valid_o && !prev_valid) obs_vrise.push_back(cyc);
         if (!valid_o && prev_valid) obs_vfall.push_back(cyc);
         prev_valid = valid_o;
         prev_waddr = weight_addr_o;
         prev_sel   = mac_sel_o;
      end else begin
         prev_valid = 1'b0;
         prev_waddr = '0;
         prev_sel   = '0;
      end
   end

   task automatic set_empty();
      empty_i = gap || (fifo_pushed <= pop_total);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      set_empty();
   endtask

   task automatic clear_all();
      obs_pop.delete(); obs_pop_cyc.delete(); obs_mac.delete(); obs_wr.delete();
      obs_vrise.delete(); obs_vfall.delete();
      exp_pop.delete(); exp_mac.delete(); exp_wr.delete();
      bias_cnt = 0; pop_in_valid = 0; wen_bad = 0;
   endtask

   // Scoreboard: one vector of stimulus and the index traffic it must produce
   task automatic push_vector(input bit add_words);
      logic [5:0] t;
      if (add_words) fifo_pushed += P;
      for (int i = 0; i < P; i++) exp_pop.push_back(IW'(i));
      for (int n = 0; n < H; n++) begin
         for (int i = 0; i < P; i++) begin
            t = {(i == 0), AW'(n * P + i), IW'(i)};
            exp_mac.push_back(t);
         end
         exp_wr.push_back(NW'(n));
      end
   endtask

   task automatic wait_rises(input int n, input int budget, output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         if (obs_vrise.size() >= n) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b0; ready_i = 1'b0; empty_i = 1'b0;
      tick(); empty_i = 1'b0; tick(); empty_i = 1'b0; #1;
      checks++;
      if (outs !== 16'h0) begin
         errors++; $display("FAIL reset_outputs got %h want 0000", outs);
      end
      set_empty();
      #1 reset_i = 1'b1;
      tick();
      checks++;
      if (busy_o !== 1'b0 || valid_o !== 1'b0 || ren_o !== 1'b0) begin
         errors++; $display("FAIL reset_idle busy=%b valid=%b ren=%b want 0 0 0", busy_o, valid_o, ren_o);
      end
   endtask

   task automatic test_basic();
      bit ok;
      logic [IW-1:0] a, e;
      logic [5:0] am, em;
      clear_all();
      ready_i = 1'b1;
      push_vector(1'b1);
      set_empty();
      wait_rises(1, 60, ok);
      tick(); tick(); tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL basic_timeout no valid_o rise"); end
      checks++;
      if (obs_pop.size() != P) begin errors++; $display("FAIL basic_pop_count got %0d want %0d", obs_pop.size(), P); end
      checks++;
      if (obs_pop_cyc.size() == P && obs_pop_cyc[P-1] - obs_pop_cyc[0] != P - 1) begin
         errors++; $display("FAIL basic_pop_consecutive span %0d want %0d", obs_pop_cyc[P-1] - obs_pop_cyc[0], P - 1);
      end
      checks++;
      if (wen_bad != 0) begin errors++; $display("FAIL basic_in_wen got %0d mismatches want 0", wen_bad); end
      while (exp_pop.size() > 0 && obs_pop.size() > 0) begin
         a = obs_pop.pop_front(); e = exp_pop.pop_front(); checks++;
         if (a !== e) begin errors++; $display("FAIL basic_in_addr got %0d want %0d", a, e); end
      end
      checks++;
      if (obs_mac.size() != H * P) begin errors++; $display("FAIL basic_mac_count got %0d want %0d", obs_mac.size(), H * P); end
      while (exp_mac.size() > 0 && obs_mac.size() > 0) begin
         am = obs_mac.pop_front(); em = exp_mac.pop_front(); checks++;
         if (am !== em) begin
            errors++; $display("FAIL basic_mac clr/addr/sel got %b/%0d/%0d want %b/%0d/%0d",
                               am[5], am[4:2], am[1:0], em[5], em[4:2], em[1:0]);
         end
      end
      checks++;
      if (obs_wr.size() != H) begin errors++; $display("FAIL basic_write_count got %0d want %0d", obs_wr.size(), H); end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         a = IW'(obs_wr.pop_front()); e = IW'(exp_wr.pop_front()); checks++;
         if (a !== e) begin errors++; $display("FAIL basic_out_neuron got %0d want %0d", a, e); end
      end
      checks++;
      if (bias_cnt != H * NB) begin errors++; $display("FAIL basic_bias_pulses got %0d want %0d", bias_cnt, H * NB); end
      if (ok && obs_pop_cyc.size() == P) begin
         checks++;
         if (obs_vrise[0] != obs_pop_cyc[P-1] + 1 + LAT) begin
            errors++; $display("FAIL basic_latency got %0d want %0d", obs_vrise[0] - obs_pop_cyc[P-1] - 1, LAT);
         end
      end
      checks++;
      if (obs_vfall.size() < 1 || obs_vfall[0] - obs_vrise[0] != 1) begin
         errors++; $display("FAIL basic_valid_width falls=%0d want one-cycle pulse", obs_vfall.size());
      end
   endtask

   task automatic test_gap();
      bit ok;
      int base;
      logic [IW-1:0] a, e;
      clear_all();
      ready_i = 1'b1;
      base = pop_total;
      push_vector(1'b1);
      set_empty();
      for (int k = 0; k < 20 && pop_total - base < 2; k++) tick();
      gap = 1'b1;
      set_empty();
      for (int k = 0; k < 3; k++) begin
         #1;
         checks++;
         if (ren_o !== 1'b0 || in_addr_o !== 2'd2 || busy_o !== 1'b1) begin
            errors++; $display("FAIL gap_hold ren=%b in_addr=%0d busy=%b want 0 2 1", ren_o, in_addr_o, busy_o);
         end
         if (k == 2) gap = 1'b0;
         tick();
      end
      wait_rises(1, 60, ok);
      tick(); tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL gap_timeout no valid_o rise"); end
      while (exp_pop.size() > 0 && obs_pop.size() > 0) begin
         a = obs_pop.pop_front(); e = exp_pop.pop_front(); checks++;
         if (a !== e) begin errors++; $display("FAIL gap_in_addr got %0d want %0d", a, e); end
      end
      if (ok && obs_pop_cyc.size() == P) begin
         checks++;
         if (obs_vrise[0] != obs_pop_cyc[0] + (P - 1) + 3 + 1 + LAT) begin
            errors++; $display("FAIL gap_latency got %0d want %0d", obs_vrise[0] - obs_pop_cyc[0], P + 3 + LAT);
         end
      end
   endtask

   task automatic test_backpressure();
      bit ok;
      clear_all();
      ready_i = 1'b0;
      push_vector(1'b1);
      push_vector(1'b1);
      set_empty();
      wait_rises(1, 60, ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_timeout no valid_o rise"); end
      for (int k = 0; k < 5; k++) begin
         checks++;
         if (valid_o !== 1'b1 || ren_o !== 1'b0) begin
            errors++; $display("FAIL bp_hold valid=%b ren=%b want 1 0", valid_o, ren_o);
         end
         tick();
      end
      ready_i = 1'b1;
      #1;
      checks++;
      if (valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid_before_edge got %b want 1", valid_o); end
      tick();
      checks++;
      if (valid_o !== 1'b0 || ren_o !== 1'b1 || in_addr_o !== 2'd0) begin
         errors++; $display("FAIL bp_release valid=%b ren=%b in_addr=%0d want 0 1 0", valid_o, ren_o, in_addr_o);
      end
      wait_rises(2, 60, ok);
      tick(); tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL bp_second_timeout no second valid_o rise"); end
      checks++;
      if (pop_in_valid != 0) begin errors++; $display("FAIL bp_pop_in_output got %0d want 0", pop_in_valid); end
   endtask

   task automatic test_reset_mid();
      bit ok;
      logic [IW-1:0] a, e;
      logic [5:0] am, em;
      clear_all();
      ready_i = 1'b1;
      push_vector(1'b1);
      set_empty();
      ok = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (weight_addr_o == 3'd5) begin ok = 1'b1; break; end
         tick();
      end
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_timeout weight_addr_o never 5"); end
      fifo_pushed += P;
      set_empty();
      #1 reset_i = 1'b0;
      #1;
      checks++;
      if (outs !== 16'h0) begin errors++; $display("FAIL rstmid_outputs got %h want 0000", outs); end
      tick(); tick(); #1;
      checks++;
      if (outs !== 16'h0) begin errors++; $display("FAIL rstmid_held got %h want 0000", outs); end
      clear_all();
      push_vector(1'b0);
      reset_i = 1'b1;
      wait_rises(1, 60, ok);
      tick(); tick(); tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL rstmid_reload_timeout no valid_o rise"); end
      checks++;
      if (obs_pop.size() != P) begin errors++; $display("FAIL rstmid_pop_count got %0d want %0d", obs_pop.size(), P); end
      if (ok && obs_pop_cyc.size() == P) begin
         checks++;
         if (obs_vrise[0] != obs_pop_cyc[P-1] + 1 + LAT) begin
            errors++; $display("FAIL rstmid_latency got %0d want %0d", obs_vrise[0] - obs_pop_cyc[P-1] - 1, LAT);
         end
      end
      while (exp_pop.size() > 0 && obs_pop.size() > 0) begin
         a = obs_pop.pop_front(); e = exp_pop.pop_front(); checks++;
         if (a !== e) begin errors++; $display("FAIL rstmid_in_addr got %0d want %0d", a, e); end
      end
      while (exp_mac.size() > 0 && obs_mac.size() > 0) begin
         am = obs_mac.pop_front(); em = exp_mac.pop_front(); checks++;
         if (am !== em) begin
            errors++; $display("FAIL rstmid_mac clr/addr/sel got %b/%0d/%0d want %b/%0d/%0d",
                               am[5], am[4:2], am[1:0], em[5], em[4:2], em[1:0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      bit ok;
      logic [NW-1:0] a, e;
      clear_all();
      ready_i = 1'b1;
      push_vector(1'b1);
      push_vector(1'b1);
      set_empty();
      wait_rises(2, 120, ok);
      tick(); tick(); tick();
      checks++;
      if (!ok) begin errors++; $display("FAIL b2b_timeout fewer than two valid_o rises"); end
      if (ok) begin
         checks++;
         if (obs_vrise[1] - obs_vrise[0] != P + LAT + 1) begin
            errors++; $display("FAIL b2b_spacing got %0d want %0d", obs_vrise[1] - obs_vrise[0], P + LAT + 1);
         end
         checks++;
         if (obs_pop_cyc.size() < 2 * P || obs_pop_cyc[P] != obs_vrise[0] + 1) begin
            errors++; $display("FAIL b2b_first_pop pops=%0d want pop at cycle %0d", obs_pop_cyc.size(), obs_vrise[0] + 1);
         end
      end
      checks++;
      if (obs_wr.size() != 2 * H) begin errors++; $display("FAIL b2b_write_count got %0d want %0d", obs_wr.size(), 2 * H); end
      while (exp_wr.size() > 0 && obs_wr.size() > 0) begin
         a = obs_wr.pop_front(); e = exp_wr.pop_front(); checks++;
         if (a !== e) begin errors++; $display("FAIL b2b_out_neuron got %0d want %0d", a, e); end
      end
      checks++;
      if (bias_cnt != 2 * H * NB) begin errors++; $display("FAIL b2b_bias_pulses got %0d want %0d", bias_cnt, 2 * H * NB); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gap();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1);
   end

endmodule
